instr_ram_arbiter: RTL and testbench
====================================

Name: instr_ram_arbiter

Overview:
Two-requester controller in front of the single-port instruction RAM (1-cycle synchronous read, write on clock edge when read_not_write=0). It shares the RAM between the CPU fetch path (reads) and the program loader (writes). It sequences each access through a small FSM, validates addresses, and enforces a write lock. It sits between the fetch stage/loader and the instr_ram instance.

Parameters:
ADDRESS_BUS_WIDTH, 12, byte address width
INSTRUCTION_WIDTH, 29, instruction word width
NUM_INSTRUCTION_WORDS, 512, RAM depth in words
WORD_CNT_WIDTH, 10, width of loaded-word counter (saturating)

Ports:
clk  in  1  system clock; all logic on posedge
reset_n  in  1  synchronous, active-low reset
fetch_req  in  1  read request; held until fetch_valid
fetch_addr  in  ADDRESS_BUS_WIDTH  byte address of instruction
fetch_valid  out  1  one-cycle response pulse
fetch_instr  out  INSTRUCTION_WIDTH  read data; valid with fetch_valid
fetch_err  out  1  with fetch_valid: bad address
load_req  in  1  write request; held until load_ack
load_addr  in  ADDRESS_BUS_WIDTH  byte address to write
load_data  in  INSTRUCTION_WIDTH  word to write
load_ack  out  1  one-cycle completion pulse
load_err  out  1  with load_ack: bad address or locked
prog_lock  in  1  1 = reject all writes
words_loaded  out  WORD_CNT_WIDTH  count of committed writes
ram_address  out  ADDRESS_BUS_WIDTH  to instr_ram address
ram_read_not_write  out  1  to instr_ram; 0 only in WRITE state
ram_wdata  out  INSTRUCTION_WIDTH  write data to RAM
ram_rdata  in  INSTRUCTION_WIDTH  instr_ram read data

Behaviour:
- Reset (reset_n=0 at posedge): state IDLE; fetch_valid=0, fetch_err=0, fetch_instr=0, load_ack=0, load_err=0, words_loaded=0, last_grant=LOADER (so fetch wins first contention); ram_address=0, ram_wdata=0.
- ram_read_not_write is decoded from the state: 1 in every state except WRITE, including during reset. The RAM is never written outside WRITE.
- Address check: bad if addr[1:0]!=0 or addr >= NUM_INSTRUCTION_WORDS*4. Bad requests never touch the RAM.
- States: IDLE, RD_ISSUE, RD_CAPT, WRITE, RESP.
- IDLE, arbitration:
  - Only fetch_req: grant fetch.
  - Only load_req: grant load.
  - Both: grant the one not equal to last_grant (round-robin), then update last_grant.
  - Request address and data are latched into internal registers, which drive ram_address/ram_wdata.
- Read path (request seen in IDLE at cycle T):
  - RD_ISSUE at T+1: RAM samples the address.
  - RD_CAPT at T+2: ram_rdata is valid and is registered.
  - RESP at T+3: fetch_valid=1 with fetch_instr.
- Write path:
  - WRITE at T+1: RAM commits at the end of the cycle; words_loaded increments (saturating at all-ones).
  - RESP at T+2: load_ack=1.
- Bad or locked request: IDLE goes directly to RESP at T+1 with ack/valid and err=1. fetch_instr=0. No RAM access, no count.
- prog_lock is sampled in IDLE only. Lock rising during WRITE does not abort that write.
- RESP lasts exactly one cycle and performs no arbitration; the next state is always IDLE. The requester must drop or change its request in the cycle after its pulse. A still-asserted request re-arbitrates in IDLE.
- No new requests are accepted outside IDLE. A pending requester simply waits; its request must stay stable.
- Reset mid-operation: the FSM returns to IDLE and no pulse is generated. A WRITE coinciding with the reset edge commits, because the RAM is not reset, but is not counted or acked.
- Output pulses (valid/ack/err) are registered and are high for only the RESP cycle.

Decomposition:
- Shared parameters include file holds:
  - ADDRESS_BUS_WIDTH, INSTRUCTION_WIDTH, NUM_INSTRUCTION_WORDS
  - FSM state encodings (3-bit)
  - Requester IDs FETCH=0, LOADER=1
- One sub-module: rr_arbiter2 (two requests, last_grant register, grant one-hot, update enable). The FSM, address check and counter stay in instr_ram_arbiter.

Test Plan:
- Load 0x1100010 at addr 0x000 → load_ack at T+2, load_err=0, words_loaded=1, ram_read_not_write low exactly 1 cycle. Then fetch 0x000 → fetch_valid at T+3 with fetch_instr=0x1100010.
- fetch_req and load_req rise together after reset (load 0x3312000 to 0x008, fetch 0x008):
  - Fetch is served first and returns the old contents.
  - Load is served next.
  - A repeated fetch returns 0x3312000.
  - Grant alternates across 4 contended rounds.
- Misaligned fetch 0x006 → fetch_valid+fetch_err at T+1, fetch_instr=0. Load to 0x800 → load_ack+load_err, words_loaded unchanged, ram_read_not_write never 0.
- prog_lock=1, load 0x2003030 to 0x00C → load_err=1. Fetch 0x00C returns the prior value. Deassert lock and retry → success.
- reset_n=0 during RD_CAPT → no fetch_valid, state IDLE, all outputs at reset values. The next fetch completes normally.
- 1024 writes after preloading the counter path → words_loaded saturates at 1023, no wrap.

Source files
------------

// File: rtl/instr_ram_arbiter_pkg.sv
// Shared widths, FSM encodings and requester IDs for the instruction RAM arbiter.
// Also holds the byte-address legality check used by both request paths.
package instr_ram_arbiter_pkg;

    localparam int DEF_ADDRESS_BUS_WIDTH     = 12;
    localparam int DEF_INSTRUCTION_WIDTH     = 29;
    localparam int DEF_NUM_INSTRUCTION_WORDS = 512;
    localparam int DEF_WORD_CNT_WIDTH        = 10;

    localparam logic REQ_FETCH  = 1'b0;
    localparam logic REQ_LOADER = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ISSUE = 3'd1,
        ST_RD_CAPT  = 3'd2,
        ST_WRITE    = 3'd3,
        ST_RESP     = 3'd4
    } state_t;

    // A byte address is legal only if word aligned and inside the RAM.
    function automatic logic addr_is_bad(input logic [31:0] byte_addr,
                                         input int unsigned num_words);
        return (byte_addr[1:0] != 2'b00) || (byte_addr >= num_words * 4);
    endfunction

endpackage

// File: rtl/instr_ram_arbiter_if.sv
// Fetch, loader and RAM-side signals of the instruction RAM arbiter.
// slave is the arbiter's view; master is the view of everything around it.
interface instr_ram_arbiter_if
    import instr_ram_arbiter_pkg::*;
#(
    parameter int ADDRESS_BUS_WIDTH = DEF_ADDRESS_BUS_WIDTH,
    parameter int INSTRUCTION_WIDTH = DEF_INSTRUCTION_WIDTH,
    parameter int WORD_CNT_WIDTH    = DEF_WORD_CNT_WIDTH
);
    logic                         fetch_req;
    logic [ADDRESS_BUS_WIDTH-1:0] fetch_addr;
    logic                         fetch_valid;
    logic [INSTRUCTION_WIDTH-1:0] fetch_instr;
    logic                         fetch_err;

    logic                         load_req;
    logic [ADDRESS_BUS_WIDTH-1:0] load_addr;
    logic [INSTRUCTION_WIDTH-1:0] load_data;
    logic                         load_ack;
    logic                         load_err;
    logic                         prog_lock;
    logic [WORD_CNT_WIDTH-1:0]    words_loaded;

    logic [ADDRESS_BUS_WIDTH-1:0] ram_address;
    logic                         ram_read_not_write;
    logic [INSTRUCTION_WIDTH-1:0] ram_wdata;
    logic [INSTRUCTION_WIDTH-1:0] ram_rdata;

    modport slave (
        input  fetch_req, fetch_addr, load_req, load_addr, load_data, prog_lock, ram_rdata,
        output fetch_valid, fetch_instr, fetch_err, load_ack, load_err, words_loaded,
               ram_address, ram_read_not_write, ram_wdata
    );

    modport master (
        output fetch_req, fetch_addr, load_req, load_addr, load_data, prog_lock, ram_rdata,
        input  fetch_valid, fetch_instr, fetch_err, load_ack, load_err, words_loaded,
               ram_address, ram_read_not_write, ram_wdata
    );

endinterface

// File: rtl/instr_ram_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: a lone request always wins, a tie goes to
// the requester that did not win the previous tie.
module rr_arbiter2
    import instr_ram_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       update_en,
    output logic [1:0] grant
);
    logic last_grant_reg;
    logic last_grant_next;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_grant
            assign grant[gi] = req[gi] && (!req[1-gi] || (last_grant_reg != 1'(gi)));
        end
    endgenerate

    // Only a real tie moves the round-robin pointer.
    always_comb begin
        last_grant_next = last_grant_reg;
        if (update_en && (&req)) begin
            last_grant_next = grant[REQ_LOADER];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_grant_reg <= REQ_LOADER;
        end else begin
            last_grant_reg <= last_grant_next;
        end
    end

endmodule

// File: rtl/instr_ram_arbiter.sv
// Shares the single-port instruction RAM between CPU fetch (reads) and the
// program loader (writes), with address checking and a write lock.
module instr_ram_arbiter
    import instr_ram_arbiter_pkg::*;
#(
    parameter int ADDRESS_BUS_WIDTH     = DEF_ADDRESS_BUS_WIDTH,
    parameter int INSTRUCTION_WIDTH     = DEF_INSTRUCTION_WIDTH,
    parameter int NUM_INSTRUCTION_WORDS = DEF_NUM_INSTRUCTION_WORDS,
    parameter int WORD_CNT_WIDTH        = DEF_WORD_CNT_WIDTH
)(
    input  logic                clk,
    input  logic                reset_n,
    instr_ram_arbiter_if.slave  bus
);
    state_t                       state_reg, state_next;
    logic [ADDRESS_BUS_WIDTH-1:0] addr_reg, addr_next;
    logic [INSTRUCTION_WIDTH-1:0] wdata_reg, wdata_next;
    logic [INSTRUCTION_WIDTH-1:0] fetch_instr_reg, fetch_instr_next;
    logic                         fetch_valid_reg, fetch_valid_next;
    logic                         fetch_err_reg, fetch_err_next;
    logic                         load_ack_reg, load_ack_next;
    logic                         load_err_reg, load_err_next;
    logic [WORD_CNT_WIDTH-1:0]    words_reg, words_next;

    logic [1:0] grant;
    logic       arb_update;
    logic       fetch_bad;
    logic       load_bad;

    assign fetch_bad = addr_is_bad(32'(bus.fetch_addr), NUM_INSTRUCTION_WORDS);
    assign load_bad  = addr_is_bad(32'(bus.load_addr), NUM_INSTRUCTION_WORDS);

    rr_arbiter2 u_rr_arbiter2 (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       ({bus.load_req, bus.fetch_req}),
        .update_en (arb_update),
        .grant     (grant)
    );

    always_comb begin
        state_next       = state_reg;
        addr_next        = addr_reg;
        wdata_next       = wdata_reg;
        fetch_instr_next = fetch_instr_reg;
        fetch_valid_next = 1'b0;
        fetch_err_next   = 1'b0;
        load_ack_next    = 1'b0;
        load_err_next    = 1'b0;
        words_next       = words_reg;
        arb_update       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (|grant) begin
                    arb_update = 1'b1;
                    if (grant[REQ_LOADER]) begin
                        // Rejected writes leave the RAM-facing registers untouched.
                        if (load_bad || bus.prog_lock) begin
                            state_next    = ST_RESP;
                            load_ack_next = 1'b1;
                            load_err_next = 1'b1;
                        end else begin
                            addr_next  = bus.load_addr;
                            wdata_next = bus.load_data;
                            state_next = ST_WRITE;
                        end
                    end else begin
                        if (fetch_bad) begin
                            state_next       = ST_RESP;
                            fetch_valid_next = 1'b1;
                            fetch_err_next   = 1'b1;
                            fetch_instr_next = '0;
                        end else begin
                            addr_next  = bus.fetch_addr;
                            state_next = ST_RD_ISSUE;
                        end
                    end
                end
            end
            ST_RD_ISSUE: state_next = ST_RD_CAPT;
            ST_RD_CAPT: begin
                state_next       = ST_RESP;
                fetch_valid_next = 1'b1;
                fetch_instr_next = bus.ram_rdata;
            end
            ST_WRITE: begin
                state_next    = ST_RESP;
                load_ack_next = 1'b1;
                words_next    = (&words_reg) ? words_reg : words_reg + 1'b1;
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg       <= ST_IDLE;
            addr_reg        <= '0;
            wdata_reg       <= '0;
            fetch_instr_reg <= '0;
            fetch_valid_reg <= 1'b0;
            fetch_err_reg   <= 1'b0;
            load_ack_reg    <= 1'b0;
            load_err_reg    <= 1'b0;
            words_reg       <= '0;
        end else begin
            state_reg       <= state_next;
            addr_reg        <= addr_next;
            wdata_reg       <= wdata_next;
            fetch_instr_reg <= fetch_instr_next;
            fetch_valid_reg <= fetch_valid_next;
            fetch_err_reg   <= fetch_err_next;
            load_ack_reg    <= load_ack_next;
            load_err_reg    <= load_err_next;
            words_reg       <= words_next;
        end
    end

    // Write strobe decoded straight from the state so it can never glitch low elsewhere.
    assign bus.ram_read_not_write = (state_reg != ST_WRITE);
    assign bus.ram_address        = addr_reg;
    assign bus.ram_wdata          = wdata_reg;
    assign bus.fetch_valid        = fetch_valid_reg;
    assign bus.fetch_instr        = fetch_instr_reg;
    assign bus.fetch_err          = fetch_err_reg;
    assign bus.load_ack           = load_ack_reg;
    assign bus.load_err           = load_err_reg;
    assign bus.words_loaded       = words_reg;

endmodule

// File: tb/tb_instr_ram_arbiter.sv
// Directed bench for instr_ram_arbiter with a behavioural 1-cycle-read RAM.
// Latencies are counted in falling edges from the IDLE cycle that sees the request.
module tb_instr_ram_arbiter;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   wr_cycles = 0;

    always #5 clk = ~clk;

    instr_ram_arbiter_if bus ();

    instr_ram_arbiter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [28:0] ram_mem [0:511];

    initial begin
        for (int i = 0; i < 512; i++) ram_mem[i] = '0;
    end

    always @(posedge clk) begin
        if (bus.ram_read_not_write === 1'b0) begin
            ram_mem[bus.ram_address[10:2]] <= bus.ram_wdata;
            wr_cycles = wr_cycles + 1;
        end
        bus.ram_rdata <= ram_mem[bus.ram_address[10:2]];
    end

    typedef struct {
        bit          is_load;
        logic [11:0] addr;
        logic [28:0] data;
        bit          lock;
        logic [28:0] exp_instr;
        bit          exp_err;
        int          exp_lat;
        int          exp_words;
        int          exp_wr;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic apply_reset();
        bus.fetch_req = 1'b0;
        bus.load_req  = 1'b0;
        bus.prog_lock = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic do_req(input bit is_load, input logic [11:0] a, input logic [28:0] d,
                          output int lat, output logic err, output logic [28:0] instr);
        bit got;
        got = 1'b0;
        lat = -1;
        err = 1'bx;
        instr = 'x;
        @(negedge clk);
        if (is_load) begin
            bus.load_req  = 1'b1;
            bus.load_addr = a;
            bus.load_data = d;
        end else begin
            bus.fetch_req  = 1'b1;
            bus.fetch_addr = a;
        end
        for (int n = 1; n <= 20 && !got; n++) begin
            @(negedge clk);
            if (is_load && bus.load_ack) begin
                got = 1'b1; lat = n; err = bus.load_err;
            end else if (!is_load && bus.fetch_valid) begin
                got = 1'b1; lat = n; err = bus.fetch_err; instr = bus.fetch_instr;
            end
        end
        bus.fetch_req = 1'b0;
        bus.load_req  = 1'b0;
    endtask

    // Both requesters assert together; reports which one was answered first.
    task automatic contend(input logic [11:0] fa, input logic [11:0] la, input logic [28:0] ld,
                           output int first, output logic [28:0] got_instr);
        bit fdone, ldone;
        fdone = 1'b0; ldone = 1'b0; first = -1; got_instr = 'x;
        @(negedge clk);
        bus.fetch_req = 1'b1; bus.fetch_addr = fa;
        bus.load_req = 1'b1; bus.load_addr = la; bus.load_data = ld;
        for (int n = 0; n < 30 && !(fdone && ldone); n++) begin
            @(negedge clk);
            if (bus.fetch_valid) begin
                fdone = 1'b1; got_instr = bus.fetch_instr; bus.fetch_req = 1'b0;
                if (first < 0) first = 0;
            end
            if (bus.load_ack) begin
                ldone = 1'b1; bus.load_req = 1'b0;
                if (first < 0) first = 1;
            end
        end
        bus.fetch_req = 1'b0;
        bus.load_req  = 1'b0;
        check("contend_both_done", 32'({fdone, ldone}), 32'h3);
    endtask

    initial begin
        int lat, wr0, first, errs, pulses;
        logic err;
        logic [28:0] instr;
        int exp_first [4];
        logic [28:0] exp_rr_instr [4];

        bus.fetch_req = 1'b0; bus.fetch_addr = '0;
        bus.load_req = 1'b0; bus.load_addr = '0; bus.load_data = '0;
        bus.prog_lock = 1'b0;

        //            load  addr     data          lock instr        err lat words wr
        vecs[0]  = '{1'b1, 12'h000, 29'h1100010,  1'b0, 29'h0,       1'b0, 2, 1, 1};
        vecs[1]  = '{1'b0, 12'h000, 29'h0,        1'b0, 29'h1100010, 1'b0, 3, 1, 0};
        vecs[2]  = '{1'b0, 12'h006, 29'h0,        1'b0, 29'h0,       1'b1, 1, 1, 0};
        vecs[3]  = '{1'b1, 12'h800, 29'h0001234,  1'b0, 29'h0,       1'b1, 1, 1, 0};
        vecs[4]  = '{1'b1, 12'h00C, 29'h0AAAAAA,  1'b0, 29'h0,       1'b0, 2, 2, 1};
        vecs[5]  = '{1'b1, 12'h00C, 29'h2003030,  1'b1, 29'h0,       1'b1, 1, 2, 0};
        vecs[6]  = '{1'b0, 12'h00C, 29'h0,        1'b1, 29'h0AAAAAA, 1'b0, 3, 2, 0};
        vecs[7]  = '{1'b1, 12'h00C, 29'h2003030,  1'b0, 29'h0,       1'b0, 2, 3, 1};
        vecs[8]  = '{1'b0, 12'h00C, 29'h0,        1'b0, 29'h2003030, 1'b0, 3, 3, 0};
        vecs[9]  = '{1'b0, 12'h7FC, 29'h0,        1'b0, 29'h0,       1'b0, 3, 3, 0};
        vecs[10] = '{1'b0, 12'h800, 29'h0,        1'b0, 29'h0,       1'b1, 1, 3, 0};
        vecs[11] = '{1'b1, 12'h7FC, 29'h1FFFFFFF, 1'b0, 29'h0,       1'b0, 2, 4, 1};
        vecs[12] = '{1'b0, 12'h7FC, 29'h0,        1'b0, 29'h1FFFFFFF, 1'b0, 3, 4, 0};
        vecs[13] = '{1'b1, 12'h00D, 29'h0000001,  1'b0, 29'h0,       1'b1, 1, 4, 0};
        vecs[14] = '{1'b0, 12'hFFD, 29'h0,        1'b0, 29'h0,       1'b1, 1, 4, 0};

        // Reset values
        @(negedge clk);
        check("rst_rnw_in_reset", 32'(bus.ram_read_not_write), 32'h1);
        apply_reset();
        check("rst_fetch_valid", 32'(bus.fetch_valid), 32'h0);
        check("rst_fetch_err", 32'(bus.fetch_err), 32'h0);
        check("rst_fetch_instr", 32'(bus.fetch_instr), 32'h0);
        check("rst_load_ack", 32'(bus.load_ack), 32'h0);
        check("rst_load_err", 32'(bus.load_err), 32'h0);
        check("rst_words", 32'(bus.words_loaded), 32'h0);
        check("rst_ram_addr", 32'(bus.ram_address), 32'h0);
        check("rst_ram_wdata", 32'(bus.ram_wdata), 32'h0);
        check("rst_rnw", 32'(bus.ram_read_not_write), 32'h1);

        for (int i = 0; i < 15; i++) begin
            bus.prog_lock = vecs[i].lock;
            wr0 = wr_cycles;
            do_req(vecs[i].is_load, vecs[i].addr, vecs[i].data, lat, err, instr);
            $display("vec %0d load=%0d addr=%h lat=%0d err=%0d instr=%h words=%0d",
                     i, vecs[i].is_load, vecs[i].addr, lat, err, instr, bus.words_loaded);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            if (!vecs[i].is_load)
                check($sformatf("vec%0d_instr", i), 32'(instr), 32'(vecs[i].exp_instr));
            check($sformatf("vec%0d_words", i), 32'(bus.words_loaded), 32'(vecs[i].exp_words));
            check($sformatf("vec%0d_wr_cycles", i), 32'(wr_cycles - wr0), 32'(vecs[i].exp_wr));
        end
        bus.prog_lock = 1'b0;

        // Reset while the read sits in RD_CAPT
        do_req(1'b0, 12'h000, 29'h0, lat, err, instr);
        check("pre_rst_fetch", 32'(instr), 32'h1100010);
        @(negedge clk);
        bus.fetch_req = 1'b1; bus.fetch_addr = 12'h000;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        bus.fetch_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("midrst_fetch_valid", 32'(bus.fetch_valid), 32'h0);
        check("midrst_fetch_instr", 32'(bus.fetch_instr), 32'h0);
        check("midrst_words", 32'(bus.words_loaded), 32'h0);
        check("midrst_ram_addr", 32'(bus.ram_address), 32'h0);
        check("midrst_ram_wdata", 32'(bus.ram_wdata), 32'h0);
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.fetch_valid || bus.load_ack) pulses++;
        end
        check("midrst_no_pulse", 32'(pulses), 32'h0);
        do_req(1'b0, 12'h000, 29'h0, lat, err, instr);
        $display("post-reset fetch lat=%0d instr=%h", lat, instr);
        check("postrst_lat", 32'(lat), 32'd3);
        check("postrst_instr", 32'(instr), 32'h1100010);

        // First contention after reset goes to fetch
        apply_reset();
        contend(12'h008, 12'h008, 29'h3312000, first, instr);
        $display("contend first=%0d instr=%h", first, instr);
        check("cont_fetch_first", 32'(first), 32'h0);
        check("cont_old_data", 32'(instr), 32'h0);
        check("cont_words", 32'(bus.words_loaded), 32'h1);
        do_req(1'b0, 12'h008, 29'h0, lat, err, instr);
        check("cont_refetch", 32'(instr), 32'h3312000);

        exp_first[0] = 1; exp_rr_instr[0] = 29'h0111111;
        exp_first[1] = 0; exp_rr_instr[1] = 29'h0111111;
        exp_first[2] = 1; exp_rr_instr[2] = 29'h0333333;
        exp_first[3] = 0; exp_rr_instr[3] = 29'h0333333;
        for (int r = 0; r < 4; r++) begin
            contend(12'h010, 12'h010, 29'(32'h0111111 * (r + 1)), first, instr);
            $display("rr round %0d first=%0d instr=%h", r, first, instr);
            check($sformatf("rr%0d_first", r), 32'(first), 32'(exp_first[r]));
            check($sformatf("rr%0d_instr", r), 32'(instr), 32'(exp_rr_instr[r]));
        end

        // Counter saturation
        apply_reset();
        errs = 0;
        for (int i = 0; i < 1025; i++) begin
            do_req(1'b1, 12'((i % 512) * 4), 29'(i), lat, err, instr);
            if (lat != 2 || err !== 1'b0) errs++;
            if (i == 1022) check("sat_words_1023", 32'(bus.words_loaded), 32'd1023);
        end
        $display("saturation run: words=%0d errs=%0d", bus.words_loaded, errs);
        check("sat_write_errs", 32'(errs), 32'h0);
        check("sat_words_hold", 32'(bus.words_loaded), 32'd1023);
        do_req(1'b0, 12'h000, 29'h0, lat, err, instr);
        check("sat_last_data", 32'(instr), 32'd1024);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
